// File: rtl/mult_dispatcher_if.sv
// rtl/mult_dispatcher_if.sv - operand, multiplier and result handshake bundle for mult_dispatcher
interface mult_dispatcher_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;

  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_res;
  logic        mul_done;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_err;
  logic [7:0]  ops_cnt;

  // slave is the dispatcher side; master is whatever feeds operands and emulates the multiplier
  modport slave (
    input  in_valid, in_a, in_b, mul_res, mul_done, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_res, out_err, ops_cnt
  );

  modport master (
    output in_valid, in_a, in_b, mul_res, mul_done, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_res, out_err, ops_cnt
  );
endinterface

// File: rtl/mult_dispatcher.sv
// rtl/mult_dispatcher.sv - single-outstanding dispatcher to an external multiplier with timeout
module mult_dispatcher #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  timer;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] res_q;
  logic        err_q;
  logic [7:0]  cnt_q;

  logic accept;
  logic zero_op;
  logic done_hit;
  logic tmo_hit;
  logic deliver;

  assign accept   = (state == S_IDLE) && bus.in_valid;
  assign zero_op  = (bus.in_a == 8'd0) || (bus.in_b == 8'd0);
  // done takes priority over the timeout in the final WAIT cycle
  assign done_hit = (state == S_WAIT) && bus.mul_done;
  assign tmo_hit  = (state == S_WAIT) && !bus.mul_done && (timer == TMO_LAST);
  assign deliver  = (state == S_HOLD) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = zero_op ? S_HOLD : S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (done_hit || tmo_hit) state_nxt = S_HOLD;
      S_HOLD:   if (bus.out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.mul_start = (state == S_LAUNCH);
    bus.out_valid = (state == S_HOLD);
  end

  // operands only reload on accept, so they stay stable through LAUNCH, WAIT and HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= 8'd0;
      op_b <= 8'd0;
    end else if (accept) begin
      op_a <= bus.in_a;
      op_b <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 8'd0;
    end else if (state == S_LAUNCH) begin
      timer <= 8'd0;
    end else if (state == S_WAIT) begin
      timer <= timer + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 16'd0;
      err_q <= 1'b0;
    end else if (accept && zero_op) begin
      res_q <= 16'd0;
      err_q <= 1'b0;
    end else if (done_hit) begin
      res_q <= bus.mul_res;
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      res_q <= 16'd0;
      err_q <= 1'b1;
    end
  end

  // only error-free deliveries count; the counter wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (deliver && !err_q) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.mul_a   = op_a;
  assign bus.mul_b   = op_b;
  assign bus.out_res = res_q;
  assign bus.out_err = err_q;
  assign bus.ops_cnt = cnt_q;

endmodule

// File: doc/mult_dispatcher.md
MULT_DISPATCHER -- requirements
Module: mult_dispatcher

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYC SHALL be declared with default 32; it is the maximum number of WAIT cycles allowed before an error completion (legal range 2..255).
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 IN_VALID  in  1  operand pair offered.
REQ-006 IN_READY  out  1  dispatcher can accept an operand pair.
REQ-007 IN_A, IN_B  in  8 each  unsigned operands.
REQ-008 MUL_START  out  1  start pulse to the multiplier.
REQ-009 MUL_A, MUL_B  out  8 each  operands to the multiplier (LOADA/LOADB side).
REQ-010 MUL_RES  in  16  multiplier product.
REQ-011 MUL_DONE  in  1  multiplier completion flag.
REQ-012 OUT_VALID  out  1  result available.
REQ-013 OUT_READY  in  1  consumer accepts the result.
REQ-014 OUT_RES  out  16  product.
REQ-015 OUT_ERR  out  1  result produced by timeout (OUT_RES=0).
REQ-016 OPS_CNT  out  8  count of error-free results delivered.

Function
REQ-017 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, HOLD.
REQ-018 IDLE: IN_READY=1; on IN_VALID&IN_READY, IN_A/IN_B SHALL be registered into MUL_A/MUL_B.
REQ-019 From IDLE on accept: if either operand is 0, the block SHALL go to HOLD with OUT_RES=0, OUT_ERR=0, and no MUL_START; otherwise it SHALL go to LAUNCH.
REQ-020 LAUNCH: MUL_START SHALL be 1 for exactly this one cycle and the WAIT timer SHALL be cleared; next state is WAIT.
REQ-021 MUL_A/MUL_B SHALL remain stable from LAUNCH until the block re-enters IDLE.
REQ-022 WAIT: the timer SHALL increment once per cycle; if MUL_DONE=1, OUT_RES SHALL be set to MUL_RES, OUT_ERR to 0, and the next state to HOLD.
REQ-023 WAIT: if MUL_DONE=0 and timer==TIMEOUT_CYC-1, OUT_RES SHALL be set to 0, OUT_ERR to 1, and the next state to HOLD; WAIT therefore lasts at most TIMEOUT_CYC cycles.
REQ-024 If MUL_DONE=1 in the timeout cycle, DONE SHALL win and the result is error-free.
REQ-025 MUL_DONE SHALL be ignored in IDLE, LAUNCH and HOLD.
REQ-026 HOLD: OUT_VALID=1, with OUT_RES/OUT_ERR held stable; on OUT_READY=1, the next state SHALL be IDLE.
REQ-027 IN_READY SHALL be 0 in LAUNCH, WAIT and HOLD; no second operation may overlap.
REQ-028 Latency (nonzero operands, accept in cycle t): MUL_START is high in cycle t+1; if DONE is first seen in WAIT cycle d, OUT_VALID is high from cycle d+1.
REQ-029 Latency (zero operand, accept in cycle t): OUT_VALID SHALL be high in cycle t+1.
REQ-030 OPS_CNT SHALL increment by 1 on each OUT_VALID&OUT_READY with OUT_ERR=0, wrapping from 255 to 0; error results SHALL NOT count.
REQ-031 OUT_RES is a 16-bit unsigned value; no truncation is permitted (255*255=0xFE01 is representable).

Reset
REQ-032 RST_N=0 SHALL immediately force state=IDLE, timer=0, MUL_A=MUL_B=0, MUL_START=0, OUT_VALID=0, OUT_RES=0, OUT_ERR=0, OPS_CNT=0; IN_READY=1 while in IDLE.
REQ-033 Reset asserted mid-operation (LAUNCH/WAIT/HOLD) SHALL abandon the operation; a pending result is lost, and a MUL_DONE arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-034 Reset check: after RST_N pulse -> all outputs 0 except IN_READY=1; OPS_CNT=0.
REQ-035 Basic: IN_A=5, IN_B=25 accepted; model asserts MUL_DONE with MUL_RES=125 four cycles after START -> single-cycle MUL_START, OUT_RES=0x007D, OUT_ERR=0, OPS_CNT=1.
REQ-036 Zero bypass: IN_A=0, IN_B=200 -> no MUL_START, OUT_VALID one cycle after accept, OUT_RES=0, OUT_ERR=0, OPS_CNT increments.
REQ-037 Timeout: TIMEOUT_CYC=8, MUL_DONE never asserted -> OUT_VALID at accept+10, OUT_ERR=1, OUT_RES=0, OPS_CNT unchanged; a second run with DONE in the 8th WAIT cycle -> OUT_ERR=0.
REQ-038 Backpressure: OUT_READY held low 10 cycles with IN_VALID=1 -> OUT_VALID/OUT_RES stable, IN_READY=0, no new accept; on release, return to IDLE and the next pair is accepted.
REQ-039 Mid-op reset and wrap: RST_N pulsed in WAIT, then late MUL_DONE -> no OUT_VALID; 256 error-free operations -> OPS_CNT wraps to 0.
